// File: rtl/rotary_event_accum.sv
// Accumulates rotary cw/ccw detent pulses into a position value,
// with same-direction speed acceleration and wrap or saturate ends.
module rotary_event_accum #(
    parameter int WIDTH        = 8,
    parameter int ACCEL_WINDOW = 2500000,
    parameter int FAST_STEP    = 4,
    parameter bit WRAP         = 1'b1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             rotary_cw,
    input  logic             rotary_ccw,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             fast
);

    localparam int TW = $clog2(ACCEL_WINDOW + 1);

    localparam logic [TW-1:0]    WIN      = TW'(ACCEL_WINDOW);
    localparam logic [TW-1:0]    TONE     = TW'(1);
    localparam logic [WIDTH:0]   FAST_INC = (WIDTH+1)'(FAST_STEP);
    localparam logic [WIDTH:0]   SLOW_INC = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic             FAST_OK  = (FAST_STEP != 1);

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_CW,
        DIR_CCW
    } dir_e;

    logic [WIDTH-1:0] value_q, value_d;
    logic             changed_q, changed_d;
    logic             fast_q, fast_d;
    logic [TW-1:0]    timer_q, timer_d;
    dir_e             dir_q, dir_d;

    logic             ev_valid;
    dir_e             ev_dir;
    logic             use_fast;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_val;

    // Event decode and step arithmetic in WIDTH+1 bits.
    always_comb begin
        ev_valid = rotary_cw ^ rotary_ccw;
        ev_dir   = rotary_cw ? DIR_CW : DIR_CCW;
        use_fast = (dir_q == ev_dir) && (timer_q < WIN);
        step     = use_fast ? FAST_INC : SLOW_INC;
        ext      = {1'b0, value_q};
        sum      = ext + step;
        diff     = ext - step;
        next_val = value_q;
        if (ev_dir == DIR_CW) begin
            if (!WRAP && sum[WIDTH]) begin
                next_val = MAX_VAL;
            end else begin
                next_val = sum[WIDTH-1:0];
            end
        end else begin
            if (!WRAP && diff[WIDTH]) begin
                next_val = '0;
            end else begin
                next_val = diff[WIDTH-1:0];
            end
        end
    end

    // Clear wins over a simultaneous event; the timer never wraps.
    always_comb begin
        value_d   = value_q;
        changed_d = 1'b0;
        fast_d    = fast_q;
        dir_d     = dir_q;
        timer_d   = timer_q;
        if (timer_q < WIN) begin
            timer_d = timer_q + TONE;
        end
        unique case (1'b1)
            clear: begin
                value_d   = '0;
                changed_d = (value_q != '0);
                fast_d    = 1'b0;
                dir_d     = DIR_NONE;
                timer_d   = WIN;
            end
            (ev_valid && !clear): begin
                value_d   = next_val;
                changed_d = (next_val != value_q);
                fast_d    = use_fast && FAST_OK;
                dir_d     = ev_dir;
                timer_d   = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            value_q   <= '0;
            changed_q <= 1'b0;
            fast_q    <= 1'b0;
            dir_q     <= DIR_NONE;
            timer_q   <= WIN;
        end else begin
            value_q   <= value_d;
            changed_q <= changed_d;
            fast_q    <= fast_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
        end
    end

    assign value   = value_q;
    assign changed = changed_q;
    assign fast    = fast_q;

endmodule

// File: tb/tb_rotary_event_accum.sv
// Bench for rotary_event_accum: wrap and saturate instances driven
// in parallel, table vectors, corner sequences and a random run.
module tb_rotary_event_accum;

    localparam int W    = 8;
    localparam int AW   = 16;
    localparam int FS   = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int FAR  = -1000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cw    = 1'b0;
    logic ccw   = 1'b0;
    logic clr   = 1'b0;

    logic [W-1:0] val_w, val_s;
    logic         chg_w, chg_s;
    logic         fast_w, fast_s;

    int checks = 0;
    int errors = 0;

    int m_val_w, m_val_s, m_dir, m_last, m_cyc;
    bit m_chg_w, m_chg_s, m_fast;

    rotary_event_accum #(
        .WIDTH(W), .ACCEL_WINDOW(AW),
        .FAST_STEP(FS), .WRAP(1'b1)
    ) u_wrap (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .rotary_cw(cw), .rotary_ccw(ccw), .clear(clr),
        .value(val_w), .changed(chg_w), .fast(fast_w)
    );

    rotary_event_accum #(
        .WIDTH(W), .ACCEL_WINDOW(AW),
        .FAST_STEP(FS), .WRAP(1'b0)
    ) u_sat (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .rotary_cw(cw), .rotary_ccw(ccw), .clear(clr),
        .value(val_s), .changed(chg_s), .fast(fast_s)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_val_w = 0;
        m_val_s = 0;
        m_dir   = 0;
        m_last  = FAR;
        m_chg_w = 0;
        m_chg_s = 0;
        m_fast  = 0;
    endtask

    // Fast means: same direction as the last accepted event and no
    // more than AW edges since it.
    task automatic model_step(bit c, bit cc, bit cl);
        int d, st, nw, ns;
        bit f;
        m_cyc++;
        m_chg_w = 0;
        m_chg_s = 0;
        if (cl) begin
            m_chg_w = (m_val_w != 0);
            m_chg_s = (m_val_s != 0);
            m_val_w = 0;
            m_val_s = 0;
            m_dir   = 0;
            m_last  = FAR;
            m_fast  = 0;
        end else if (c != cc) begin
            d  = c ? 1 : -1;
            f  = (d == m_dir) && (m_cyc - m_last <= AW);
            st = f ? FS : 1;
            nw = m_val_w + d * st;
            nw = ((nw % (MAXV + 1)) + MAXV + 1) % (MAXV + 1);
            ns = m_val_s + d * st;
            if (ns > MAXV) ns = MAXV;
            if (ns < 0) ns = 0;
            m_chg_w = (nw != m_val_w);
            m_chg_s = (ns != m_val_s);
            m_val_w = nw;
            m_val_s = ns;
            m_fast  = f && (FS != 1);
            m_dir   = d;
            m_last  = m_cyc;
        end
    endtask

    task automatic cmp_model(string tag);
        chk({tag, ".val_w"}, int'(val_w), m_val_w);
        chk({tag, ".chg_w"}, int'(chg_w), int'(m_chg_w));
        chk({tag, ".fast_w"}, int'(fast_w), int'(m_fast));
        chk({tag, ".val_s"}, int'(val_s), m_val_s);
        chk({tag, ".chg_s"}, int'(chg_s), int'(m_chg_s));
        chk({tag, ".fast_s"}, int'(fast_s), int'(m_fast));
    endtask

    task automatic tick(bit c, bit cc, bit cl, string tag);
        @(negedge clk);
        cw  = c;
        ccw = cc;
        clr = cl;
        @(posedge clk);
        model_step(c, cc, cl);
        #1;
        cmp_model(tag);
        cw  = 1'b0;
        ccw = 1'b0;
        clr = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".val_w"}, int'(val_w), 0);
        chk({tag, ".chg_w"}, int'(chg_w), 0);
        chk({tag, ".fast_w"}, int'(fast_w), 0);
        chk({tag, ".val_s"}, int'(val_s), 0);
        chk({tag, ".chg_s"}, int'(chg_s), 0);
        chk({tag, ".fast_s"}, int'(fast_s), 0);
    endtask

    typedef struct {
        int gap;
        bit c;
        bit cc;
        bit cl;
        int ew;
        bit ecw;
        int es;
        bit ecs;
        bit ef;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{0,  1, 0, 0, 1,   1, 1, 1, 0};
        tbl[1]  = '{4,  1, 0, 0, 5,   1, 5, 1, 1};
        tbl[2]  = '{4,  1, 0, 0, 9,   1, 9, 1, 1};
        tbl[3]  = '{0,  1, 1, 0, 9,   0, 9, 0, 1};
        tbl[4]  = '{0,  1, 0, 1, 0,   1, 0, 1, 0};
        tbl[5]  = '{40, 1, 0, 0, 1,   1, 1, 1, 0};
        tbl[6]  = '{40, 1, 0, 0, 2,   1, 2, 1, 0};
        tbl[7]  = '{40, 1, 0, 0, 3,   1, 3, 1, 0};
        tbl[8]  = '{0,  0, 1, 0, 2,   1, 2, 1, 0};
        tbl[9]  = '{0,  0, 1, 0, 254, 1, 0, 1, 1};
        tbl[10] = '{0,  0, 1, 0, 250, 1, 0, 0, 1};
        tbl[11] = '{20, 0, 1, 0, 249, 1, 0, 0, 0};
        tbl[12] = '{0,  0, 0, 1, 0,   1, 0, 0, 0};
        tbl[13] = '{0,  0, 0, 1, 0,   0, 0, 0, 0};

        m_cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            idle(tbl[i].gap);
            tick(tbl[i].c, tbl[i].cc, tbl[i].cl, "tbl");
            chk($sformatf("tbl%0d.val_w", i), int'(val_w), tbl[i].ew);
            chk($sformatf("tbl%0d.chg_w", i), int'(chg_w), int'(tbl[i].ecw));
            chk($sformatf("tbl%0d.val_s", i), int'(val_s), tbl[i].es);
            chk($sformatf("tbl%0d.chg_s", i), int'(chg_s), int'(tbl[i].ecs));
            chk($sformatf("tbl%0d.fast", i), int'(fast_w), int'(tbl[i].ef));
        end

        // Wrap at both ends.
        tick(1'b0, 1'b1, 1'b0, "wrapdn");
        chk("wrap_0_minus_1", int'(val_w), 255);
        chk("sat_0_minus_1", int'(val_s), 0);
        idle(20);
        tick(1'b0, 1'b1, 1'b0, "wrapdn2");
        chk("wrap_254", int'(val_w), 254);
        idle(20);
        tick(1'b1, 1'b0, 1'b0, "rev");
        chk("wrap_rev_slow", int'(val_w), 255);
        chk("wrap_rev_fast", int'(fast_w), 0);
        tick(1'b1, 1'b0, 1'b0, "wrapup");
        chk("wrap_255_plus_4", int'(val_w), 3);
        chk("wrap_fast", int'(fast_w), 1);

        // Saturate at the top.
        tick(1'b0, 1'b0, 1'b1, "clr");
        for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, 1'b0, "ramp");
        chk("sat_ramp_253", int'(val_s), 253);
        tick(1'b1, 1'b0, 1'b0, "sattop");
        chk("sat_clamp_255", int'(val_s), 255);
        chk("sat_clamp_chg", int'(chg_s), 1);
        tick(1'b1, 1'b0, 1'b0, "satnop");
        chk("sat_nop_val", int'(val_s), 255);
        chk("sat_nop_chg", int'(chg_s), 0);
        chk("sat_nop_fast", int'(fast_s), 1);

        // Ignored double event leaves the timer running from the prior event.
        tick(1'b0, 1'b0, 1'b1, "clr");
        tick(1'b1, 1'b0, 1'b0, "d1");
        idle(2);
        tick(1'b1, 1'b1, 1'b0, "both");
        chk("both_val", int'(val_w), 1);
        chk("both_chg", int'(chg_w), 0);
        idle(2);
        tick(1'b1, 1'b0, 1'b0, "after_both");
        chk("after_both_val", int'(val_w), 5);
        chk("after_both_fast", int'(fast_w), 1);

        // Asynchronous reset between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 25) tick(1'b1, 1'b0, 1'b0, "rnd");
            else if (r < 50) tick(1'b0, 1'b1, 1'b0, "rnd");
            else if (r < 53) tick(1'b1, 1'b1, 1'b0, "rnd");
            else if (r < 56) tick(r[0], ~r[0], 1'b1, "rnd");
            else if (r < 96) tick(1'b0, 1'b0, 1'b0, "rnd");
            else idle(int'($urandom_range(5, 25)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotary_event_accum.md
Name: rotary_event_accum

Overview:
Downstream consumer of the rotary controller's single-cycle cw/ccw event pulses. Accumulates them into a WIDTH-bit position value that drives the eight-bit seven-segment display stage. Applies rotation-speed acceleration: rapid same-direction detents step by FAST_STEP instead of 1. Supports wrap or saturate at the range ends, plus a synchronous clear.

Parameters:
WIDTH, 8, width of the accumulated value; must be ≥ 2 and wide enough to hold FAST_STEP.
ACCEL_WINDOW, 2500000, cycles (50 ms at 50 MHz) within which a same-direction event counts as "fast".
FAST_STEP, 4, step applied to fast events; must be ≥ 1 and < 2^WIDTH.
WRAP, 1, 1 = modular wrap-around at the ends; 0 = saturate at 0 and 2^WIDTH-1.

Ports:
clk_clk  input  1  system clock; all state updates on the rising edge.
reset_reset_n  input  1  asynchronous active-low reset.
rotary_cw  input  1  one-cycle pulse per clockwise detent, synchronous to clk_clk.
rotary_ccw  input  1  one-cycle pulse per counter-clockwise detent, synchronous to clk_clk.
clear  input  1  synchronous clear of value and acceleration state.
value  output  WIDTH  registered accumulated position.
changed  output  1  one-cycle pulse, high in the cycle value first shows a new number.
fast  output  1  registered; high while the most recent accepted event used FAST_STEP.

Behaviour:
- Reset (reset_reset_n low, asynchronous):
  - value = 0, changed = 0, fast = 0.
  - last_dir = none; gap timer saturated at ACCEL_WINDOW, so the first event after reset is slow.
- Gap timer:
  - counts cycles since the last accepted event and saturates at ACCEL_WINDOW (no wrap).
  - Width = clog2(ACCEL_WINDOW+1).
  - Reloads to 0 in the cycle after an accepted event.
- Event accept:
  - Exactly one of rotary_cw or rotary_ccw is high in a cycle.
  - Both high in the same cycle: ignored. No value change, no changed pulse, timer and last_dir untouched.
- Step selection:
  - step = FAST_STEP when last_dir equals the current direction and timer < ACCEL_WINDOW.
  - Otherwise step = 1.
  - A direction reversal is always slow.
  - fast <= (step == FAST_STEP && FAST_STEP != 1).
- Arithmetic:
  - Compute value ± step in WIDTH+1 bits.
  - WRAP=1: keep the low WIDTH bits (modular).
  - WRAP=0: clamp to 2^WIDTH-1 on carry out, clamp to 0 on borrow.
- Latency:
  - An event sampled at edge N appears on value after edge N. This is one register stage, with no combinational path from input to output.
  - changed is high for that one cycle.
- Saturated no-op (WRAP=0 at a limit):
  - Event is accepted: timer reloads, last_dir and fast update.
  - value is unchanged, so changed = 0.
  - changed pulses only when value actually differs.
- clear:
  - Has priority over a simultaneous event.
  - value <= 0; timer <= ACCEL_WINDOW; last_dir <= none; fast <= 0.
  - changed = 1 only if value was nonzero.
- Back-to-back events on consecutive cycles are all accepted, one step per cycle.
- Asserting reset mid-operation returns every register to its reset value immediately, independent of clk_clk.

Test Plan:
1. Reset, then 3 cw pulses spaced 2×ACCEL_WINDOW apart (ACCEL_WINDOW=16) -> value 1, 2, 3; changed pulses 3 times; fast stays 0.
2. ACCEL_WINDOW=16, FAST_STEP=4, cw pulses 5 cycles apart ×3 from 0 -> value 1, 5, 9; fast = 0, 1, 1.
3. WRAP=1, value 254, then two fast cw events (step 4) -> 255 (slow first), then 3 (wrap of 255+4); one ccw from 0 -> 255.
4. WRAP=0, value 253, fast cw -> 255; another cw -> value stays 255, changed = 0. From 2, fast ccw -> 0.
5. rotary_cw and rotary_ccw both high for one cycle at value 7 -> value stays 7, changed = 0. A following cw inside the window is still judged against the previous event's timer.
6. Mid-sequence (value 9, fast = 1): assert clear together with cw -> value 0, changed = 1, fast = 0. Next, assert reset_reset_n low between clock edges -> outputs go to 0 asynchronously.
